// File: rtl/insmem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// CHECK state exists only when INSMEM_LOADER_CHECKSUM_EN is defined.
package insmem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
`ifdef INSMEM_LOADER_CHECKSUM_EN
      ST_CHECK = 3'd3,
`endif
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   // Highest word-aligned byte address for a given address width.
   function automatic logic [31:0] last_word_addr(input int unsigned addr_w);
      logic [31:0] all_ones;
      all_ones = (32'd1 << addr_w) - 32'd1;
      return all_ones & ~32'd3;
   endfunction

endpackage

// File: rtl/insmem_word_packer.sv
// Little-endian byte-to-word packer: shift register plus 2-bit byte count.
module insmem_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        capture,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_last
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;

   // Next word/count: new bytes enter at the top so byte 0 ends in [7:0].
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         cnt_d = 2'd0;
      end else if (capture) begin
         word_d = {byte_in, word_q[31:8]};
         cnt_d  = cnt_q + 2'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Packer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         word_q <= 32'd0;
         cnt_q  <= 2'd0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word      = word_q;
   assign word_last = capture & (cnt_q == 2'd3);

endmodule

// File: rtl/insmem_loader.sv
// Serial program loader: packs bytes into words and writes them to instruction memory.
// Optional checksum byte after HALT when INSMEM_LOADER_CHECKSUM_EN is defined.
module insmem_loader
   import insmem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              write_en,
   output logic [31:0]       data,
   output logic [ADDR_W-1:0] addr_wr,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [31:0]       LAST_ADDR_32 = last_word_addr(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR    = LAST_ADDR_32[ADDR_W-1:0];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              drop_q, drop_d;
   logic              wen_q, wen_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef INSMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic        start_ok_s;
   logic        capture_s;
   logic        word_last_s;
   logic [31:0] word_s;

   assign start_ok_s = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign capture_s  = rx_valid & (state_q == ST_RECV);

   insmem_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (start_ok_s),
      .capture   (capture_s),
      .byte_in   (rx_data),
      .word      (word_s),
      .word_last (word_last_s)
   );

   // State and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
         wen_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef INSMEM_LOADER_CHECKSUM_EN
         csum_q  <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
         wen_q   <= wen_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef INSMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   // Next-state, address and sticky-error logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      err_d   = err_q;
      drop_d  = drop_q;
`ifdef INSMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RECV;
               addr_d  = '0;
               err_d   = 1'b0;
               drop_d  = 1'b0;
`ifdef INSMEM_LOADER_CHECKSUM_EN
               csum_d  = 8'd0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_RECV: begin
`ifdef INSMEM_LOADER_CHECKSUM_EN
            if (capture_s) begin
               csum_d = csum_q ^ rx_data;
            end else begin
               csum_d = csum_q;
            end
`endif
            if (word_last_s) begin
               state_d = ST_WRITE;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_WRITE: begin
            // A byte arriving during the write cycle cannot be stored.
            drop_d = drop_q | rx_valid;
            addr_d = addr_q + ADDR_W'(4);
            if (word_s == HALT_WORD) begin
`ifdef INSMEM_LOADER_CHECKSUM_EN
               state_d = ST_CHECK;
`else
               state_d = ST_DONE;
               err_d   = drop_q | rx_valid;
`endif
            end else if (addr_q == LAST_ADDR) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = ST_RECV;
            end
         end
`ifdef INSMEM_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (rx_valid) begin
               state_d = ST_DONE;
               err_d   = drop_q | (rx_data != csum_q);
            end else begin
               state_d = ST_CHECK;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs decoded from the upcoming state.
   always_comb begin
      wen_d  = (state_d == ST_WRITE);
      done_d = (state_d == ST_DONE);
`ifdef INSMEM_LOADER_CHECKSUM_EN
      busy_d = (state_d == ST_RECV) | (state_d == ST_WRITE) | (state_d == ST_CHECK);
`else
      busy_d = (state_d == ST_RECV) | (state_d == ST_WRITE);
`endif
   end

   assign write_en = wen_q;
   assign data     = word_s;
   assign addr_wr  = addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = err_q;

endmodule

// File: tb/tb_insmem_loader.sv
// Self-checking bench for insmem_loader; reference model derives expected writes from word lists.
module tb_insmem_loader;

   localparam int          ADDR_W = 8;
   localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        rx_data = 8'd0;
   logic              rx_valid = 1'b0;
   logic              write_en;
   logic [31:0]       data;
   logic [ADDR_W-1:0] addr_wr;
   logic              busy;
   logic              done;
   logic              error;

   insmem_loader #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .write_en(write_en), .data(data), .addr_wr(addr_wr), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [39:0] obs_q[$];
   logic [39:0] exp_q[$];
   int          n_words;
   int          drops;
   logic        overflow;
   logic [7:0]  xor_acc;

   // Record every memory write as {addr, data}.
   always @(negedge clk) begin
      if (write_en === 1'b1) obs_q.push_back({addr_wr, data});
   end

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, o, e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
      @(negedge clk);
      reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_wen"},   64'(write_en), 64'd0);
      chk({tag, "_data"},  64'(data),     64'd0);
      chk({tag, "_addr"},  64'(addr_wr),  64'd0);
      chk({tag, "_busy"},  64'(busy),     64'd0);
      chk({tag, "_done"},  64'(done),     64'd0);
      chk({tag, "_error"}, 64'(error),    64'd0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic begin_load();
      obs_q.delete(); exp_q.delete();
      n_words = 0; drops = 0; overflow = 1'b0; xor_acc = 8'd0;
      pulse_start();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      idle($urandom_range(0, 2));
   endtask

   // Model: word n lands at byte address 4n; a non-halt 64th word is an overflow.
   task automatic model_word(input logic [31:0] w);
      exp_q.push_back({8'(n_words * 4), w});
      n_words++;
      if (n_words == 64 && w != HALT) overflow = 1'b1;
      xor_acc = xor_acc ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endtask

   task automatic send_word(input logic [31:0] w);
      model_word(w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   // Last byte immediately followed by a junk byte that falls in the write cycle.
   task automatic send_word_drop(input logic [31:0] w, input logic [7:0] junk);
      model_word(w);
      for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
      @(negedge clk);
      rx_data = w[31:24]; rx_valid = 1'b1;
      @(negedge clk);
      rx_data = junk;
      @(negedge clk);
      rx_valid = 1'b0;
      drops++;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      do w = $urandom; while (w == HALT);
      return w;
   endfunction

   task automatic finish_load(input string tag, input logic bad_csum);
      logic exp_err;
      int   k;
      exp_err = (drops > 0) | overflow;
`ifdef INSMEM_LOADER_CHECKSUM_EN
      if (!overflow) begin
         idle(3);
         chk({tag, "_check_busy"}, 64'(busy), 64'd1);
         send_byte(bad_csum ? (xor_acc ^ 8'h01) : xor_acc);
         exp_err = exp_err | bad_csum;
      end
`else
      chk({tag, "_bad_csum_unused"}, 64'(bad_csum), 64'd0);
`endif
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_done"},  64'(done),  64'd1);
      chk({tag, "_busy"},  64'(busy),  64'd0);
      chk({tag, "_error"}, 64'(exp_err), 64'(error));
      chk({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_write%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
   endtask

   initial begin
      int nw;
      do_reset();
      check_reset_state("reset");

      // Directed two-word program.
      begin_load();
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_done", 64'(done), 64'd0);
      send_word(32'h2008_0013);
      send_word(HALT);
      finish_load("prog", 1'b0);

      // Random programs of random length.
      for (int r = 0; r < 4; r++) begin
         begin_load();
         nw = $urandom_range(1, 8);
         for (int i = 0; i < nw; i++) send_word(rand_word());
         send_word(HALT);
         finish_load($sformatf("rand%0d", r), 1'b0);
      end

      // Fill all 64 words without a halt.
      begin_load();
      for (int i = 0; i < 64; i++) send_word(rand_word());
      finish_load("ovf", 1'b0);
      if (obs_q.size() > 0) chk("ovf_last_addr", 64'(obs_q[obs_q.size()-1][39:32]), 64'd252);
      obs_q.delete();
      for (int i = 0; i < 8; i++) send_byte(8'($urandom));
      idle(4);
      chk("ovf_no_more_writes", 64'(obs_q.size()), 64'd0);
      chk("ovf_done_held", 64'(done), 64'd1);

      // Reset in the middle of the second word.
      begin_load();
      send_word(rand_word());
      send_byte(8'h11);
      send_byte(8'h22);
      do_reset();
      check_reset_state("midreset");
      begin_load();
      send_word(rand_word());
      send_word(HALT);
      finish_load("after_reset", 1'b0);

      // Byte dropped in the write cycle, then start pulsed mid-load.
      begin_load();
      send_word_drop(rand_word(), 8'h5A);
      pulse_start();
      chk("midstart_busy", 64'(busy), 64'd1);
      chk("midstart_addr", 64'(addr_wr), 64'd4);
      send_word(rand_word());
      send_word(HALT);
      finish_load("drop", 1'b0);

`ifdef INSMEM_LOADER_CHECKSUM_EN
      begin_load();
      send_word(32'h0403_0201);
      send_word(HALT);
      chk("csum_model", 64'(xor_acc), 64'h04);
      finish_load("csum_good", 1'b0);
      begin_load();
      send_word(32'h0403_0201);
      send_word(HALT);
      finish_load("csum_bad", 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
